// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the delta-sigma receive path: PCM format limits,
// the 16-bit saturator and the CIC accumulator width rule.
package dsp_pkg;

    localparam int PCM_W = 16;
    localparam logic signed [15:0] PCM_MAX = 16'sh7fff;
    localparam logic signed [15:0] PCM_MIN = 16'sh8000;

    // Clamp a wide signed value into the signed 16-bit PCM range.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return PCM_MAX;
        end else if (x < -32'sd32768) begin
            return PCM_MIN;
        end else begin
            return x[15:0];
        end
    endfunction

    // Integrator/comb width for a 3rd-order CIC with unit differential delay.
    function automatic int cic_acc_w(input int decim);
        return 3 * $clog2(decim) + 1;
    endfunction

endpackage

// File: rtl/dsadc_decimator_if.sv
// Bit-stream input and PCM output bundle of the delta-sigma decimator.
// The master side drives the bit stream; the slave side is the decimator.
interface dsadc_decimator_if;
    import dsp_pkg::*;

    logic                    en;
    logic                    bit_in;
    logic signed [PCM_W-1:0] pcm_out;
    logic                    pcm_valid;

    modport master (output en, output bit_in, input pcm_out, input pcm_valid);
    modport slave  (input en, input bit_in, output pcm_out, output pcm_valid);

endinterface

// File: rtl/cic_comb_stage.sv
// One CIC comb section: dout = din - previous din, evaluated only when fired.
// The delay register advances only on fire so it always holds the previous
// sample-rate value, and dout_vld follows fire by one clock.
module cic_comb_stage #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fire,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         dout_vld
);

    logic [W-1:0] dinDly_q;
    logic [W-1:0] dout_q;
    logic         vld_q;

    // Difference against the last fired sample, modular in W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dinDly_q <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= fire;
            if (fire) begin
                dout_q   <= din - dinDly_q;
                dinDly_q <= din;
            end
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;

endmodule

// File: rtl/dsadc_decimator.sv
// 3rd-order CIC decimator turning a 1-bit delta-sigma stream into Q1.15 PCM.
// Optional feature macro: DSADC_DCBLOCK_EN adds a one-pole DC blocker after
// the saturator and one clock of latency.
module dsadc_decimator
    import dsp_pkg::*;
#(
    parameter int DECIM = 64
) (
    input logic               clk,
    input logic               rst_n,
    dsadc_decimator_if.slave  bus
);

    localparam int ACC_W = cic_acc_w(DECIM);
    // One guard bit above ACC_W so the +full-scale result 2^(ACC_W-1) keeps a positive sign.
    localparam int DP_W  = ACC_W + 1;
    localparam int SHIFT = ACC_W - PCM_W;
    localparam int CNT_W = $clog2(DECIM);

    if ((DECIM < 64) || (DECIM > 256) || ((DECIM & (DECIM - 1)) != 0)) begin : g_badDecim
        $error("dsadc_decimator: DECIM must be a power of two in 64..256");
    end

    logic [DP_W-1:0]  integ1_q, integ2_q, integ3_q;
    logic [DP_W-1:0]  step_d, integ3_d;
    logic [CNT_W-1:0] decCnt_q;
    logic             capFire_d;
    logic [DP_W-1:0]  cap_q;
    logic             capVld_q;
    logic [DP_W-1:0]  c1, c2, c3;
    logic             vld1, vld2, vld3;
    logic signed [31:0] c3Wide_d;
    logic signed [15:0] satOut_d;
    logic signed [15:0] pcmOut_q;
    logic               pcmValid_q;

    assign step_d    = bus.bit_in ? DP_W'(1) : '1;
    assign integ3_d  = integ3_q + integ2_q;
    assign capFire_d = bus.en && (decCnt_q == CNT_W'(DECIM - 1));

    // Bit-rate integrator cascade and decimation counter; everything holds when en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ1_q <= '0;
            integ2_q <= '0;
            integ3_q <= '0;
            decCnt_q <= '0;
        end else if (bus.en) begin
            integ1_q <= integ1_q + step_d;
            integ2_q <= integ2_q + integ1_q;
            integ3_q <= integ3_d;
            decCnt_q <= capFire_d ? '0 : decCnt_q + 1'b1;
        end
    end

    // Latch the freshly updated third integrator once per frame and flag the comb chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q    <= '0;
            capVld_q <= 1'b0;
        end else begin
            capVld_q <= capFire_d;
            if (capFire_d) begin
                cap_q <= integ3_d;
            end
        end
    end

    cic_comb_stage #(.W(DP_W)) u_comb1 (
        .clk(clk), .rst_n(rst_n), .fire(capVld_q), .din(cap_q), .dout(c1), .dout_vld(vld1)
    );
    cic_comb_stage #(.W(DP_W)) u_comb2 (
        .clk(clk), .rst_n(rst_n), .fire(vld1), .din(c1), .dout(c2), .dout_vld(vld2)
    );
    cic_comb_stage #(.W(DP_W)) u_comb3 (
        .clk(clk), .rst_n(rst_n), .fire(vld2), .din(c2), .dout(c3), .dout_vld(vld3)
    );

    assign c3Wide_d = {{(32 - DP_W){c3[DP_W-1]}}, c3};
    assign satOut_d = sat16(c3Wide_d >>> SHIFT);

`ifdef DSADC_DCBLOCK_EN
    logic signed [15:0] xNew_q, xDly_q;
    logic               xVld_q;
    logic        [17:0] yFull_d;

    assign yFull_d = {{2{xNew_q[15]}}, xNew_q} - {{2{xDly_q[15]}}, xDly_q}
                   + {{2{pcmOut_q[15]}}, pcmOut_q} - {{2{pcmOut_q[15]}}, (pcmOut_q >>> 8)};

    // Register the saturated CIC sample as the blocker input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xNew_q <= '0;
            xVld_q <= 1'b0;
        end else begin
            xVld_q <= vld3;
            if (vld3) begin
                xNew_q <= satOut_d;
            end
        end
    end

    // DC blocker y = x - x_d + y_d - y_d/256; x_d and y_d move only on output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xDly_q     <= '0;
            pcmOut_q   <= '0;
            pcmValid_q <= 1'b0;
        end else begin
            pcmValid_q <= xVld_q;
            if (xVld_q) begin
                xDly_q   <= xNew_q;
                pcmOut_q <= sat16({{14{yFull_d[17]}}, yFull_d});
            end
        end
    end
`else
    // Output register: scaled and saturated comb result with a one-clock strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcmOut_q   <= '0;
            pcmValid_q <= 1'b0;
        end else begin
            pcmValid_q <= vld3;
            if (vld3) begin
                pcmOut_q <= satOut_d;
            end
        end
    end
`endif

    assign bus.pcm_out   = pcmOut_q;
    assign bus.pcm_valid = pcmValid_q;

endmodule
